// File: rtl/pipo_skid_reg.sv
// pipo_skid_reg: two-entry valid/ready skid buffer with falling-edge capture,
// async reset, synchronous flush and occupancy output.
module pipo_skid_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             acc, deq;

    assign out_valid = (state_q != EMPTY) & ~clr;
    assign in_ready  = (state_q != TWO) & ~clr;
    assign acc       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign data_out  = main_q;
    assign occupancy = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = data_in;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && deq) begin
                    main_d = data_in;
                end else if (acc) begin
                    skid_d  = data_in;
                    state_d = TWO;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (deq) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // acc/deq are already masked by clr, so only the state needs forcing
        if (clr) state_d = EMPTY;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_pipo_skid_reg.sv
// tb_pipo_skid_reg: directed checks on a 16-bit instance and a randomized
// run of an 8-bit instance against a queue model.
module tb_pipo_skid_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b0, a_clr = 1'b0, a_iv = 1'b0, a_or = 1'b0;
    logic [15:0] a_din = '0;
    logic        a_ir, a_ov;
    logic [15:0] a_dout;
    logic [1:0]  a_occ;

    logic        b_rst = 1'b0, b_clr = 1'b0, b_iv = 1'b0, b_or = 1'b0;
    logic [7:0]  b_din = '0;
    logic        b_ir, b_ov;
    logic [7:0]  b_dout;
    logic [1:0]  b_occ;

    int n_tests = 0;
    int n_fail  = 0;

    pipo_skid_reg #(.WIDTH(16), .RESET_VAL(16'hA5A5)) dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .in_valid(a_iv), .in_ready(a_ir),
        .data_in(a_din), .out_valid(a_ov), .out_ready(a_or), .data_out(a_dout),
        .occupancy(a_occ)
    );

    pipo_skid_reg #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .in_valid(b_iv), .in_ready(b_ir),
        .data_in(b_din), .out_valid(b_ov), .out_ready(b_or), .data_out(b_dout),
        .occupancy(b_occ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic ov, input logic ir,
                            input logic [15:0] dout, input logic [1:0] occ);
        check({tag, "_ov"}, 32'(a_ov), 32'(ov));
        check({tag, "_ir"}, 32'(a_ir), 32'(ir));
        check({tag, "_dout"}, 32'(a_dout), 32'(dout));
        check({tag, "_occ"}, 32'(a_occ), 32'(occ));
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       exp_ov, exp_ir, acc, deq, hold;
    logic [7:0] prev_dout;

    initial begin
        #2 a_rst = 1'b1; b_rst = 1'b1;
        #1 expect_a("rst", 1'b0, 1'b1, 16'hA5A5, 2'd0);
        check("b_rst_occ", 32'(b_occ), 32'd0);
        check("b_rst_dout", 32'(b_dout), 32'd0);
        #1 a_rst = 1'b0; b_rst = 1'b0;
        step;
        // streaming
        for (int i = 1; i <= 16; i++) begin
            a_iv = 1'b1; a_din = 16'(i); a_or = 1'b1;
            #1 check("str_ir", 32'(a_ir), 32'd1);
            if (i > 1) begin
                check("str_dout", 32'(a_dout), 32'(i - 1));
                check("str_occ", 32'(a_occ), 32'd1);
            end
            step;
        end
        a_iv = 1'b0;
        #1 expect_a("str_end", 1'b1, 1'b1, 16'h0010, 2'd1);
        step;
        // backpressure
        a_or = 1'b0; a_iv = 1'b1; a_din = 16'h1111;
        #1 check("bp0_occ", 32'(a_occ), 32'd0);
        step;
        a_din = 16'h2222;
        #1 expect_a("bp1", 1'b1, 1'b1, 16'h1111, 2'd1);
        step;
        a_din = 16'h3333;
        #1 expect_a("bp2", 1'b1, 1'b0, 16'h1111, 2'd2);
        step;
        #1 expect_a("bp_hold", 1'b1, 1'b0, 16'h1111, 2'd2);
        a_or = 1'b1;
        step;
        #1 expect_a("bp3", 1'b1, 1'b1, 16'h2222, 2'd1);
        step;
        a_iv = 1'b0;
        #1 expect_a("bp4", 1'b1, 1'b1, 16'h3333, 2'd1);
        step;
        #1 expect_a("bp5", 1'b0, 1'b1, 16'h3333, 2'd0);
        // flush
        a_or = 1'b0; a_iv = 1'b1; a_din = 16'hBEEF;
        step;
        a_din = 16'hCAFE;
        step;
        a_clr = 1'b1; a_din = 16'h1234; a_or = 1'b1;
        #1 expect_a("fl1", 1'b0, 1'b0, 16'hBEEF, 2'd2);
        step;
        a_clr = 1'b0; a_iv = 1'b0;
        #1 expect_a("fl2", 1'b0, 1'b1, 16'hBEEF, 2'd0);
        // reset mid-transfer
        a_iv = 1'b1; a_or = 1'b0; a_din = 16'h5555;
        step;
        a_din = 16'h6666;
        step;
        a_iv = 1'b0;
        #1 check("mr_occ", 32'(a_occ), 32'd2);
        a_rst = 1'b1;
        #1 expect_a("mr1", 1'b0, 1'b1, 16'hA5A5, 2'd0);
        a_rst = 1'b0; a_iv = 1'b1; a_din = 16'h0042;
        step;
        a_iv = 1'b0;
        #1 expect_a("mr2", 1'b1, 1'b1, 16'h0042, 2'd1);
        // randomized run on the 8-bit instance
        hold = 1'b0;
        prev_dout = '0;
        for (int c = 0; c < 10000; c++) begin
            b_iv  = 1'($urandom_range(0, 1));
            b_or  = 1'($urandom_range(0, 1));
            b_clr = ($urandom_range(0, 15) == 0);
            b_din = 8'($urandom);
            #1;
            exp_ov = (q.size() != 0) && !b_clr;
            exp_ir = (q.size() != 2) && !b_clr;
            check("rnd_ov", 32'(b_ov), 32'(exp_ov));
            check("rnd_ir", 32'(b_ir), 32'(exp_ir));
            check("rnd_occ", 32'(b_occ), 32'(q.size()));
            if (q.size() != 0) check("rnd_dout", 32'(b_dout), 32'(q[0]));
            if (hold) check("rnd_stable", 32'(b_dout), 32'(prev_dout));
            acc = b_iv && exp_ir;
            deq = exp_ov && b_or;
            hold = exp_ov && !b_or;
            prev_dout = b_dout;
            if (b_clr) q.delete();
            else begin
                if (deq) void'(q.pop_front());
                if (acc) q.push_back(b_din);
            end
            step;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
